add_result_stage: RTL

ADD_RESULT_STAGE -- requirements
Module: add_result_stage

---
 rtl/add_result_stage_pkg.sv | 22 ++
 rtl/add_result_stage_flag_gen.sv | 25 ++
 rtl/add_result_stage.sv | 114 +++++++++++
 3 files changed

// File: rtl/add_result_stage_pkg.sv
// add_result_stage_pkg
// Shared types and constants for the adder result stage.
// WIDTH normally comes from `INPUTSIZE in the project-wide define.v. The guard
// below keeps this slice buildable on its own; when define.v is compiled
// first, its value takes precedence.
`ifndef INPUTSIZE
`define INPUTSIZE 8
`endif

package add_result_stage_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int COUNT_W    = 8;

    // Flags are captured at push time and travel with the stored sum.
    typedef struct packed {
        logic carry;
        logic zero;
        logic ovf;
    } add_flags_t;

endpackage

// File: rtl/add_result_stage_flag_gen.sv
// add_flag_gen
// Purely combinational status flags for one adder result.
// Ports:
//   in_sum  [WIDTH:0]  adder output, with the carry-out in the MSB
//   a_msb, b_msb       sign bits of the operands that produced in_sum
//   carry              unsigned carry-out
//   zero               sum bits [WIDTH-1:0] are all zero
//   ovf                two's-complement overflow
module add_flag_gen #(
    parameter int WIDTH = `INPUTSIZE
) (
    input  logic [WIDTH:0] in_sum,
    input  logic           a_msb,
    input  logic           b_msb,
    output logic           carry,
    output logic           zero,
    output logic           ovf
);

    assign carry = in_sum[WIDTH];
    assign zero  = (in_sum[WIDTH-1:0] == '0);
    // Overflow occurs only when both operands share a sign and the result's sign differs.
    assign ovf   = (a_msb == b_msb) && (in_sum[WIDTH-1] != a_msb);

endmodule

// File: rtl/add_result_stage.sv
// add_result_stage
// Two-entry FIFO that buffers adder results together with their flags, and
// counts the results delivered downstream.
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   in_valid/in_ready         upstream handshake; in_ready depends on stored state only
//   in_sum, in_a_msb, in_b_msb  adder result and operand sign bits
//   out_valid/out_ready       downstream handshake for the head entry
//   out_sum, out_carry, out_zero, out_ovf  head entry; all zero while empty
//   out_count                 number of pops, modulo 256
module add_result_stage
    import add_result_stage_pkg::*;
#(
    parameter int WIDTH = `INPUTSIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH:0]     in_sum,
    input  logic               in_a_msb,
    input  logic               in_b_msb,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic               out_carry,
    output logic               out_zero,
    output logic               out_ovf,
    output logic [COUNT_W-1:0] out_count
);

    logic [WIDTH-1:0]   sum_mem_q  [FIFO_DEPTH];
    logic [WIDTH-1:0]   sum_mem_d  [FIFO_DEPTH];
    add_flags_t         flag_mem_q [FIFO_DEPTH];
    add_flags_t         flag_mem_d [FIFO_DEPTH];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         occ_q, occ_d;
    logic [COUNT_W-1:0] count_q, count_d;

    add_flags_t new_flags;
    logic       push;
    logic       pop;

    add_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .in_sum (in_sum),
        .a_msb  (in_a_msb),
        .b_msb  (in_b_msb),
        .carry  (new_flags.carry),
        .zero   (new_flags.zero),
        .ovf    (new_flags.ovf)
    );

    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        sum_mem_d  = sum_mem_q;
        flag_mem_d = flag_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        occ_d      = occ_q + {1'b0, push} - {1'b0, pop};

        if (push) begin
            sum_mem_d[wr_ptr_q]  = in_sum[WIDTH-1:0];
            flag_mem_d[wr_ptr_q] = new_flags;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                sum_mem_q[i]  <= '0;
                flag_mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            count_q  <= '0;
        end else begin
            sum_mem_q  <= sum_mem_d;
            flag_mem_q <= flag_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            count_q    <= count_d;
        end
    end

    // The head is masked while empty so stale storage never reaches the outputs.
    always_comb begin
        out_sum   = '0;
        out_carry = 1'b0;
        out_zero  = 1'b0;
        out_ovf   = 1'b0;
        if (out_valid) begin
            out_sum   = sum_mem_q[rd_ptr_q];
            out_carry = flag_mem_q[rd_ptr_q].carry;
            out_zero  = flag_mem_q[rd_ptr_q].zero;
            out_ovf   = flag_mem_q[rd_ptr_q].ovf;
        end
    end

    assign out_count = count_q;

endmodule
